// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access size encoding and FSM states.
package dmem_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_e;

    typedef enum {IDLE, WAIT, RESP} dmem_state_e;

endpackage

// File: rtl/dmem_responder_lsu_lane.sv
// Byte-lane steering: store byte enables and replicated store word, plus load
// extraction with sign/zero extension.
import dmem_pkg::*;

module lsu_lane (
    input  size_e       size,
    input  logic [1:0]  addr,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] ldata
);

    logic [31:0] sh;
    logic [15:0] half;

    always_comb begin
        be    = '0;
        wword = '0;
        ldata = '0;
        sh    = rword >> {addr, 3'b000};
        half  = addr[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_B: begin
                be    = 4'b0001 << addr;
                wword = {4{wdata[7:0]}};
                ldata = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            SZ_H: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
                ldata = uns ? {16'h0, half} : {{16{half[15]}}, half};
            end
            SZ_W: begin
                be    = 4'b1111;
                wword = wdata;
                ldata = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request port, WAIT_CYCLES wait states,
// lane-steered stores, extended loads and fault reporting over a word RAM.
import dmem_pkg::*;

module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_e state, state_nx;
    logic [31:0] cnt, cnt_nx;

    logic        l_we, l_uns;
    size_e       l_size;
    logic [31:0] l_addr, l_wdata;

    logic        cur_we, cur_uns;
    size_e       cur_size;
    logic [31:0] cur_addr, cur_wdata;
    logic        fault, commit;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic [31:0] wword, ldata;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero wait states the commit happens on the accept edge itself, so
    // the access is taken from the live inputs in IDLE, else from the latch.
    always_comb begin
        if (state == IDLE) begin
            cur_we    = req_we;
            cur_uns   = req_unsigned;
            cur_size  = size_e'(req_size);
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_we    = l_we;
            cur_uns   = l_uns;
            cur_size  = l_size;
            cur_addr  = l_addr;
            cur_wdata = l_wdata;
        end
    end

    assign fault = (cur_size == SZ_BAD)
                || (cur_size == SZ_H && cur_addr[0])
                || (cur_size == SZ_W && cur_addr[1:0] != 2'b00)
                || ({2'b00, cur_addr[31:2]} >= DEPTH_WORDS);
    assign idx    = cur_addr[AW+1:2];
    assign commit = (state_nx == RESP) && (state != RESP);

    lsu_lane u_lane (
        .size  (cur_size),
        .addr  (cur_addr[1:0]),
        .uns   (cur_uns),
        .wdata (cur_wdata),
        .rword (mem[idx]),
        .be    (be),
        .wword (wword),
        .ldata (ldata)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (req_valid) begin
                cnt_nx   = '0;
                state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt == 32'(WAIT_CYCLES - 1)) state_nx = RESP;
                else                             cnt_nx   = cnt + 32'd1;
            end
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            l_we      <= 1'b0;
            l_uns     <= 1'b0;
            l_size    <= SZ_B;
            l_addr    <= '0;
            l_wdata   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && req_valid) begin
                l_we    <= req_we;
                l_uns   <= req_unsigned;
                l_size  <= size_e'(req_size);
                l_addr  <= req_addr;
                l_wdata <= req_wdata;
            end
            if (commit) begin
                rsp_err   <= fault;
                rsp_rdata <= (fault || cur_we) ? '0 : ldata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && cur_we && !fault) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters).
module tb_dmem_responder;

    localparam int unsigned W     = 2;
    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; hold = cycles rsp_ready stays low once the response is up.
    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output logic [31:0] r, output logic e, output int l);
        logic [31:0] r0;
        logic        e0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        l = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata;
                req_size = ~size; req_we = ~we;
            end
            l++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) l = 99;
        r = rsp_rdata; e = rsp_err;
        r0 = r; e0 = e;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, r0);
            chk("hold_err", {31'b0, rsp_err}, {31'b0, e0});
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        if (hold > 0) begin
            chk("release_req_ready", {31'b0, req_ready}, 32'd1);
            chk("release_valid", {31'b0, rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

        // word store / load and latency
        xact(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
        chk("sw_err", {31'b0, er}, 32'd0);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_lat", lat, 1 + W);
        xact(0, 2'b10, 0, 32'h10, 32'h0, 0, rd, er, lat);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", {31'b0, er}, 32'd0);
        chk("lw_lat", lat, 1 + W);

        // byte lane 3
        xact(1, 2'b00, 0, 32'h13, 32'h00000080, 0, rd, er, lat);
        xact(0, 2'b00, 0, 32'h13, 32'h0, 0, rd, er, lat);
        chk("lb_s", rd, 32'hFFFFFF80);
        xact(0, 2'b00, 1, 32'h13, 32'h0, 0, rd, er, lat);
        chk("lb_u", rd, 32'h00000080);
        xact(0, 2'b10, 0, 32'h10, 32'h0, 0, rd, er, lat);
        chk("lw_after_sb", rd, 32'h80ADBEEF);

        // halves
        xact(1, 2'b01, 0, 32'h12, 32'h00001234, 0, rd, er, lat);
        xact(0, 2'b01, 0, 32'h12, 32'h0, 0, rd, er, lat);
        chk("lh_s", rd, 32'h00001234);
        xact(1, 2'b01, 0, 32'h11, 32'h0000FFFF, 0, rd, er, lat);
        chk("sh_mis_err", {31'b0, er}, 32'd1);
        chk("sh_mis_rdata", rd, 32'd0);
        chk("sh_mis_lat", lat, 1 + W);
        xact(0, 2'b10, 0, 32'h10, 32'h0, 0, rd, er, lat);
        chk("lw_after_sh", rd, 32'h1234BEEF);
        xact(1, 2'b00, 0, 32'h11, 32'hFFFFFF5A, 0, rd, er, lat);
        xact(0, 2'b10, 0, 32'h10, 32'h0, 0, rd, er, lat);
        chk("lw_lane1", rd, 32'h12345AEF);
        xact(0, 2'b01, 1, 32'h10, 32'h0, 0, rd, er, lat);
        chk("lhu_lo", rd, 32'h00005AEF);
        xact(1, 2'b01, 0, 32'h14, 32'hFFFFF00D, 0, rd, er, lat);
        xact(0, 2'b01, 0, 32'h14, 32'h0, 0, rd, er, lat);
        chk("lh_neg", rd, 32'hFFFFF00D);
        xact(0, 2'b00, 1, 32'h15, 32'h0, 0, rd, er, lat);
        chk("lbu_lane1", rd, 32'h000000F0);

        // faults
        xact(1, 2'b10, 0, 32'h0, 32'h0, 0, rd, er, lat);
        xact(0, 2'b10, 0, DEPTH * 4, 32'h0, 0, rd, er, lat);
        chk("oor_ld_err", {31'b0, er}, 32'd1);
        chk("oor_ld_rdata", rd, 32'd0);
        xact(1, 2'b10, 0, DEPTH * 4, 32'hAAAAAAAA, 0, rd, er, lat);
        chk("oor_st_err", {31'b0, er}, 32'd1);
        xact(1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 0, rd, er, lat);
        chk("bad_size_err", {31'b0, er}, 32'd1);
        xact(0, 2'b11, 0, 32'h10, 32'h0, 0, rd, er, lat);
        chk("bad_size_ld_rdata", rd, 32'd0);
        xact(0, 2'b10, 0, 32'h12, 32'h0, 0, rd, er, lat);
        chk("lw_mis_err", {31'b0, er}, 32'd1);
        chk("lw_mis_rdata", rd, 32'd0);
        xact(0, 2'b10, 0, 32'h0, 32'h0, 0, rd, er, lat);
        chk("word0_untouched", rd, 32'd0);
        xact(0, 2'b10, 0, 32'h10, 32'h0, 0, rd, er, lat);
        chk("word10_untouched", rd, 32'h12345AEF);

        // response backpressure
        xact(0, 2'b10, 0, 32'h10, 32'h0, 5, rd, er, lat);
        chk("hold_data", rd, 32'h12345AEF);

        // reset aborts a store in WAIT
        xact(1, 2'b10, 0, 32'h20, 32'h11223344, 0, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_in_wait", {31'b0, req_ready}, 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_valid", {31'b0, rsp_valid}, 32'd0);
        chk("abort_rdata", rsp_rdata, 32'd0);
        chk("abort_err", {31'b0, rsp_err}, 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_idle_valid", {31'b0, rsp_valid}, 32'd0);
        xact(0, 2'b10, 0, 32'h20, 32'h0, 0, rd, er, lat);
        chk("abort_no_write", rd, 32'h11223344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
